imem_fetch_responder: RTL and testbench
=======================================

# imem_fetch_responder

Instruction-memory responder for the ARM-LP fetch path. It accepts byte addresses produced by the program counter, reads 32-bit LEGv8 instruction words from an internal word-addressed memory, and returns them in order through a valid/ready handshake. A fixed read latency and a response buffer absorb decode-side backpressure. A flush input discards all in-flight fetches when the PC redirects on a taken branch.

## Interface
Parameters:
- DEPTH, 256: instruction memory size in 32-bit words; power of two.
- LATENCY, 2: cycles from request acceptance to response, with no backpressure; legal range 1..4.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  fetch request present.
- req_ready  out  1  request accepted on a cycle where req_valid && req_ready.
- req_addr  in  32  byte address, taken from the PC readAddress.
- flush  in  1  PC redirect; discards every outstanding fetch.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed on a cycle where rsp_valid && rsp_ready.
- rsp_instr  out  32  instruction word; 0 when faulted.
- rsp_addr  out  32  req_addr of the request this response belongs to.
- rsp_fault  out  2  00 OK, 01 misaligned, 10 out of range.
- load_en  in  1  program-load write strobe.
- load_addr  in  $clog2(DEPTH)  word index to write.
- load_data  in  32  word to write.

## Operation
- Outstanding count (occ): requests accepted but not yet consumed. Range 0..LATENCY+1.
- req_ready = flush | (occ <= LATENCY). This gives full throughput with no combinational path from rsp_ready.
- Accepted request:
  - Index = req_addr[31:2].
  - If req_addr[1:0] != 0: fault 01.
  - Else if index >= DEPTH: fault 10.
  - Misaligned takes priority over out of range.
  - A faulted request still occupies a slot and returns in order with rsp_instr = 0.
- Read pipeline: LATENCY valid-tagged stages carrying {addr, instr, fault}.
- Stage outputs feed a response FIFO of depth LATENCY+1. rsp_* is the FIFO head.
- Responses leave in acceptance order. No drops, no duplicates.
- Memory read uses contents as of the acceptance cycle.
- Load port:
  - A write takes effect after the edge.
  - A load and an accepted request to the same word in the same cycle: the request returns the old word (read-before-write).
  - Memory contents are not cleared by reset.
- Flush:
  - Clears all pipeline valids and the FIFO; occ is set to 0.
  - A request presented in the flush cycle is accepted and is the only surviving fetch.
  - A pop in the flush cycle is ignored, because flush wins.
- occ next value = occ + accept − pop. If accept and pop happen in the same cycle, occ is unchanged.

## Timing
- During reset: req_ready = 0, rsp_valid = 0, rsp_instr = 0, rsp_addr = 0, rsp_fault = 00, occ = 0, all stage valids = 0.
- First cycle after reset deasserts: req_ready = 1.
- Request accepted at edge t with the FIFO empty: rsp_valid is high during cycle t+LATENCY.
- While rsp_valid && !rsp_ready: rsp_instr, rsp_addr and rsp_fault hold stable.
- Reset asserted mid-operation: all outstanding fetches are lost. No stale response ever appears after reset.
- Flush at edge t: rsp_valid = 0 in cycle t+1, unless the FIFO refill path delivers a new response, which is only possible when LATENCY = 1 … t+1.

## Structure
- Shared package arm_lp_pkg holds:
  - INSTR_W = 32 and ADDR_W = 32.
  - fetch_fault_t enum {FAULT_NONE = 2'b00, FAULT_MISALIGN = 2'b01, FAULT_RANGE = 2'b10}.
  - A fetch_rsp_t struct {addr, instr, fault}.
- One sub-module: fetch_rsp_fifo, a synchronous FIFO.
  - Parameterized depth and payload of fetch_rsp_t.
  - Has a clear input, driven by flush.
  - Provides count, used for occ.

## Test plan
- Single fetch (LATENCY = 2): load word index 1 = 0x8B020020, then request 0x4 at cycle 0 → rsp_valid in cycle 2 with rsp_instr = 0x8B020020, rsp_addr = 0x4, fault 00.
- Streaming with rsp_ready = 1: requests 0x0, 0x4, 0x8, 0xC on consecutive cycles → four responses on consecutive cycles 2..5, in order; req_ready never drops.
- Backpressure with rsp_ready = 0 and req_valid held high → exactly 3 requests accepted, then req_ready = 0. Raise rsp_ready → 3 in-order responses with no loss or duplication.
- Flush: two fetches in flight, then flush together with a request to 0x40 → the only subsequent response has rsp_addr = 0x40; occ = 1 after the flush edge.
- Faults (DEPTH = 256):
  - 0x6 → fault 01, instr 0.
  - 0x400 → fault 10.
  - 0x402 → fault 01.
  - All three return in order among good fetches.
- Reset with 3 outstanding → cycle after reset: rsp_valid = 0, req_ready = 0. After deassert, no response appears until a new request is accepted. Memory still holds the loaded words.

Source files
------------

// File: rtl/arm_lp_pkg.sv
// Shared types for the ARM-LP fetch path: widths, fault codes and the
// response payload that travels through the fetch pipeline and buffer.
package arm_lp_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_RANGE    = 2'b10
    } fetch_fault_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [INSTR_W-1:0] instr;
        fetch_fault_t       fault;
    } fetch_rsp_t;

    // Misalignment is checked first so that an unaligned address beyond the
    // end of memory reports as misaligned rather than out of range.
    function automatic fetch_fault_t classify_fetch(input logic [ADDR_W-1:0] addr,
                                                    input logic [ADDR_W-1:0] depthWords);
        if (addr[1:0] != 2'b00) begin
            return FAULT_MISALIGN;
        end
        if ({2'b00, addr[ADDR_W-1:2]} >= depthWords) begin
            return FAULT_RANGE;
        end
        return FAULT_NONE;
    endfunction

endpackage

// File: rtl/fetch_rsp_fifo.sv
// Response buffer for the fetch responder. When the buffer is empty an
// incoming entry is presented straight at the head in the same cycle, so an
// entry that is consumed on arrival never occupies a slot. The clear input
// drops every stored entry (used on PC redirect).
module fetch_rsp_fifo
    import arm_lp_pkg::*;
#(
    parameter int  DEPTH = 3,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             push_i,
    input  fetch_rsp_t       push_data_i,
    input  logic             pop_i,
    output logic             out_valid_o,
    output fetch_rsp_t       out_data_o,
    output logic [CNT_W-1:0] count_o
);

    fetch_rsp_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty;
    logic             doWrite;
    logic             doRead;

    // Pointers wrap explicitly because DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] incPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Head selection, bypass decision and next pointer/count state.
    always_comb begin
        empty       = (count_q == '0);
        doRead      = pop_i & ~empty;
        doWrite     = push_i & ~(empty & pop_i);
        out_valid_o = ~empty | push_i;
        out_data_o  = empty ? push_data_i : mem_q[rdPtr_q];
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        count_d     = count_q;
        if (clear_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (doWrite) begin
                wrPtr_d = incPtr(wrPtr_q);
            end
            if (doRead) begin
                rdPtr_d = incPtr(rdPtr_q);
            end
            count_d = count_q + CNT_W'(doWrite) - CNT_W'(doRead);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are don't-care while the count says empty.
    always_ff @(posedge clk) begin
        if (doWrite && !clear_i && !reset) begin
            mem_q[wrPtr_q] <= push_data_i;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: accepts PC byte addresses, reads 32-bit
// words through a fixed-latency pipeline, and returns them in order through a
// bypassing response buffer. Flush discards everything in flight except a
// request presented in the same cycle.
module imem_fetch_responder
    import arm_lp_pkg::*;
#(
    parameter int  DEPTH      = 256,
    parameter int  LATENCY    = 2,
    localparam int IDX_W      = $clog2(DEPTH),
    localparam int FIFO_DEPTH = LATENCY + 1,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1),
    localparam int OCC_W      = $clog2(LATENCY + 2) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic               flush,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [INSTR_W-1:0] rsp_instr,
    output logic [ADDR_W-1:0]  rsp_addr,
    output logic [1:0]         rsp_fault,
    input  logic               load_en,
    input  logic [IDX_W-1:0]   load_addr,
    input  logic [INSTR_W-1:0] load_data
);

    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [LATENCY-1:0] stgValid_q, stgValid_d;
    fetch_rsp_t         stgData_q [LATENCY];
    fetch_rsp_t         stgData_d [LATENCY];
    logic [OCC_W-1:0]   occ;
    logic [CNT_W-1:0]   fifoCount;
    logic               accept;
    logic               pop;
    logic               headValid;
    fetch_rsp_t         headData;
    fetch_fault_t       reqFault;
    logic [IDX_W-1:0]   reqIdx;
    fetch_rsp_t         reqEntry;

    // Outstanding count and handshakes; req_ready depends only on state,
    // flush and reset, never on rsp_ready.
    always_comb begin
        occ = OCC_W'(fifoCount);
        for (int i = 0; i < LATENCY; i++) begin
            occ = occ + OCC_W'(stgValid_q[i]);
        end
        req_ready = ~reset & (flush | (occ <= OCC_W'(LATENCY)));
        accept    = req_valid & req_ready;
        pop       = headValid & rsp_ready & ~flush & ~reset;
    end

    // Decode the incoming request; memory is read combinationally so the
    // first stage captures the word as it was before any same-edge load.
    always_comb begin
        reqFault       = classify_fetch(req_addr, ADDR_W'(DEPTH));
        reqIdx         = req_addr[IDX_W+1:2];
        reqEntry.addr  = req_addr;
        reqEntry.fault = reqFault;
        reqEntry.instr = (reqFault == FAULT_NONE) ? mem_q[reqIdx] : '0;
    end

    // Read pipeline advances every cycle; flush empties the later stages
    // while the first stage still takes the request accepted this cycle.
    always_comb begin
        stgValid_d = stgValid_q;
        stgData_d  = stgData_q;
        if (flush) begin
            stgValid_d = '0;
        end else begin
            for (int i = 1; i < LATENCY; i++) begin
                stgValid_d[i] = stgValid_q[i-1];
                stgData_d[i]  = stgData_q[i-1];
            end
        end
        stgValid_d[0] = accept;
        stgData_d[0]  = reqEntry;
    end

    // Pipeline stage registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stgValid_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                stgData_q[i] <= '0;
            end
        end else begin
            stgValid_q <= stgValid_d;
            stgData_q  <= stgData_d;
        end
    end

    // Program-load port; contents survive reset.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem_q[load_addr] <= load_data;
        end
    end

    fetch_rsp_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (flush),
        .push_i      (stgValid_q[LATENCY-1] & ~flush),
        .push_data_i (stgData_q[LATENCY-1]),
        .pop_i       (pop),
        .out_valid_o (headValid),
        .out_data_o  (headData),
        .count_o     (fifoCount)
    );

    // Response outputs are forced quiet while reset is held.
    always_comb begin
        rsp_valid = headValid & ~reset;
        rsp_instr = reset ? '0 : headData.instr;
        rsp_addr  = reset ? '0 : headData.addr;
        rsp_fault = reset ? 2'b00 : headData.fault;
    end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed self-checking bench for imem_fetch_responder (DEPTH 256, LATENCY 2).
module tb_imem_fetch_responder;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_addr;
    logic [1:0]  rsp_fault;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [31:0] load_data;

    logic [31:0] expMem [0:255];
    int testsRun;
    int testsFailed;

    imem_fetch_responder #(
        .DEPTH   (256),
        .LATENCY (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_addr  (rsp_addr),
        .rsp_fault (rsp_fault),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic loadWord(input logic [7:0] idx, input logic [31:0] data);
        load_en   = 1'b1;
        load_addr = idx;
        load_data = data;
        tick();
        load_en     = 1'b0;
        expMem[idx] = data;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        #1;
        testsRun++;
        if (req_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_req_ready: got %0b expected 0", req_ready); end
        testsRun++;
        if (rsp_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_rsp_valid: got %0b expected 0", rsp_valid); end
        testsRun++;
        if (rsp_instr !== 32'h0 || rsp_addr !== 32'h0 || rsp_fault !== 2'b00) begin
            testsFailed++;
            $display("[TB] FAIL reset_rsp_fields: got instr=%h addr=%h fault=%b expected all zero", rsp_instr, rsp_addr, rsp_fault);
        end
        testsRun++;
        if (dut.occ !== 3'd0) begin testsFailed++; $display("[TB] FAIL reset_occ: got %0d expected 0", dut.occ); end
        reset = 1'b0;
        #1;
        testsRun++;
        if (req_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL post_reset_ready: got %0b expected 1", req_ready); end
        tick();
    endtask

    task automatic test_single_fetch();
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h4;
        #1;
        testsRun++;
        if (req_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL single_ready: got %0b expected 1", req_ready); end
        tick();
        req_valid = 1'b0;
        #1;
        testsRun++;
        if (rsp_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_early: got rsp_valid=%0b expected 0 in cycle 1", rsp_valid); end
        tick();
        #1;
        testsRun++;
        if (rsp_valid !== 1'b1 || rsp_instr !== 32'h8B020020 || rsp_addr !== 32'h4 || rsp_fault !== 2'b00) begin
            testsFailed++;
            $display("[TB] FAIL single_rsp: got v=%0b instr=%h addr=%h fault=%b expected v=1 instr=8b020020 addr=4 fault=00",
                     rsp_valid, rsp_instr, rsp_addr, rsp_fault);
        end
        tick();
        #1;
        testsRun++;
        if (rsp_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_after: got rsp_valid=%0b expected 0", rsp_valid); end
        tick();
    endtask

    task automatic test_streaming();
        rsp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            req_valid = (c < 4);
            req_addr  = 32'(c * 4);
            #1;
            if (c < 4) begin
                testsRun++;
                if (req_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL stream_ready c%0d: got %0b expected 1", c, req_ready); end
            end
            testsRun++;
            if (c >= 2 && c <= 5) begin
                if (rsp_valid !== 1'b1 || rsp_addr !== 32'((c - 2) * 4) || rsp_instr !== expMem[c-2]) begin
                    testsFailed++;
                    $display("[TB] FAIL stream_rsp c%0d: got v=%0b addr=%h instr=%h expected v=1 addr=%h instr=%h",
                             c, rsp_valid, rsp_addr, rsp_instr, 32'((c - 2) * 4), expMem[c-2]);
                end
            end else begin
                if (rsp_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL stream_idle c%0d: got v=%0b expected 0", c, rsp_valid); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int   accepted;
        logic acc;
        accepted  = 0;
        rsp_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            req_valid = 1'b1;
            req_addr  = 32'h8 + 32'(accepted * 4);
            #1;
            acc = req_ready;
            if (c >= 2) begin
                testsRun++;
                if (rsp_valid !== 1'b1 || rsp_addr !== 32'h8 || rsp_instr !== expMem[2]) begin
                    testsFailed++;
                    $display("[TB] FAIL bp_hold c%0d: got v=%0b addr=%h instr=%h expected v=1 addr=8 instr=%h",
                             c, rsp_valid, rsp_addr, rsp_instr, expMem[2]);
                end
            end
            tick();
            if (acc) accepted++;
        end
        req_valid = 1'b0;
        #1;
        testsRun++;
        if (accepted != 3) begin testsFailed++; $display("[TB] FAIL bp_accepted: got %0d expected 3", accepted); end
        testsRun++;
        if (req_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_ready_low: got %0b expected 0", req_ready); end
        rsp_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            testsRun++;
            if (c < 3) begin
                if (rsp_valid !== 1'b1 || rsp_addr !== 32'h8 + 32'(c * 4) || rsp_instr !== expMem[2+c]) begin
                    testsFailed++;
                    $display("[TB] FAIL bp_drain c%0d: got v=%0b addr=%h instr=%h expected v=1 addr=%h instr=%h",
                             c, rsp_valid, rsp_addr, rsp_instr, 32'h8 + 32'(c * 4), expMem[2+c]);
                end
            end else begin
                if (rsp_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_extra c%0d: got v=%0b expected 0", c, rsp_valid); end
            end
            tick();
        end
    endtask

    task automatic test_flush();
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h0;
        tick();
        req_addr  = 32'h4;
        tick();
        flush     = 1'b1;
        req_addr  = 32'h40;
        #1;
        testsRun++;
        if (req_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL flush_ready: got %0b expected 1", req_ready); end
        tick();
        flush     = 1'b0;
        req_valid = 1'b0;
        #1;
        testsRun++;
        if (rsp_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL flush_quiet: got v=%0b addr=%h expected v=0", rsp_valid, rsp_addr); end
        testsRun++;
        if (dut.occ !== 3'd1) begin testsFailed++; $display("[TB] FAIL flush_occ: got %0d expected 1", dut.occ); end
        tick();
        #1;
        testsRun++;
        if (rsp_valid !== 1'b1 || rsp_addr !== 32'h40 || rsp_instr !== expMem[16]) begin
            testsFailed++;
            $display("[TB] FAIL flush_survivor: got v=%0b addr=%h instr=%h expected v=1 addr=40 instr=%h",
                     rsp_valid, rsp_addr, rsp_instr, expMem[16]);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            #1;
            testsRun++;
            if (rsp_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL flush_stale c%0d: got v=%0b addr=%h expected v=0", c, rsp_valid, rsp_addr); end
        end
        tick();
    endtask

    task automatic test_faults();
        logic [31:0] addrs    [6];
        logic [1:0]  expFault [6];
        logic [31:0] expInstr [6];
        addrs[0] = 32'h0;   expFault[0] = 2'b00; expInstr[0] = expMem[0];
        addrs[1] = 32'h6;   expFault[1] = 2'b01; expInstr[1] = 32'h0;
        addrs[2] = 32'h4;   expFault[2] = 2'b00; expInstr[2] = expMem[1];
        addrs[3] = 32'h400; expFault[3] = 2'b10; expInstr[3] = 32'h0;
        addrs[4] = 32'h402; expFault[4] = 2'b01; expInstr[4] = 32'h0;
        addrs[5] = 32'h8;   expFault[5] = 2'b00; expInstr[5] = expMem[2];
        rsp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            req_valid = (c < 6);
            req_addr  = (c < 6) ? addrs[c] : 32'h0;
            #1;
            testsRun++;
            if (c >= 2 && c <= 7) begin
                if (rsp_valid !== 1'b1 || rsp_addr !== addrs[c-2] || rsp_fault !== expFault[c-2] || rsp_instr !== expInstr[c-2]) begin
                    testsFailed++;
                    $display("[TB] FAIL fault_rsp c%0d: got v=%0b addr=%h fault=%b instr=%h expected v=1 addr=%h fault=%b instr=%h",
                             c, rsp_valid, rsp_addr, rsp_fault, rsp_instr, addrs[c-2], expFault[c-2], expInstr[c-2]);
                end
            end else begin
                if (rsp_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL fault_idle c%0d: got v=%0b expected 0", c, rsp_valid); end
            end
            tick();
        end
    endtask

    task automatic test_load_collision();
        logic [31:0] oldWord;
        oldWord   = expMem[3];
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'hC;
        load_en   = 1'b1;
        load_addr = 8'd3;
        load_data = 32'hC0FFEE03;
        tick();
        req_valid = 1'b0;
        load_en   = 1'b0;
        expMem[3] = 32'hC0FFEE03;
        tick();
        #1;
        testsRun++;
        if (rsp_valid !== 1'b1 || rsp_addr !== 32'hC || rsp_instr !== oldWord) begin
            testsFailed++;
            $display("[TB] FAIL rbw_old: got v=%0b addr=%h instr=%h expected v=1 addr=c instr=%h", rsp_valid, rsp_addr, rsp_instr, oldWord);
        end
        tick();
        req_valid = 1'b1;
        req_addr  = 32'hC;
        tick();
        req_valid = 1'b0;
        tick();
        #1;
        testsRun++;
        if (rsp_valid !== 1'b1 || rsp_instr !== 32'hC0FFEE03) begin
            testsFailed++;
            $display("[TB] FAIL rbw_new: got v=%0b instr=%h expected v=1 instr=c0ffee03", rsp_valid, rsp_instr);
        end
        tick();
    endtask

    task automatic test_reset_midflight();
        rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            req_valid = 1'b1;
            req_addr  = 32'(c * 4);
            tick();
        end
        req_valid = 1'b0;
        reset     = 1'b1;
        #1;
        testsRun++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL midreset_during: got v=%0b ready=%0b expected 0 0", rsp_valid, req_ready);
        end
        tick();
        #1;
        testsRun++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL midreset_after_edge: got v=%0b ready=%0b expected 0 0", rsp_valid, req_ready);
        end
        tick();
        reset     = 1'b0;
        rsp_ready = 1'b1;
        #1;
        testsRun++;
        if (req_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL midreset_ready: got %0b expected 1", req_ready); end
        for (int c = 0; c < 4; c++) begin
            tick();
            #1;
            testsRun++;
            if (rsp_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset_stale c%0d: got v=%0b addr=%h expected v=0", c, rsp_valid, rsp_addr); end
        end
        tick();
        req_valid = 1'b1;
        req_addr  = 32'h4;
        tick();
        req_valid = 1'b0;
        tick();
        #1;
        testsRun++;
        if (rsp_valid !== 1'b1 || rsp_addr !== 32'h4 || rsp_instr !== 32'h8B020020) begin
            testsFailed++;
            $display("[TB] FAIL midreset_mem: got v=%0b addr=%h instr=%h expected v=1 addr=4 instr=8b020020", rsp_valid, rsp_addr, rsp_instr);
        end
        tick();
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_addr    = 32'h0;
        flush       = 1'b0;
        rsp_ready   = 1'b0;
        load_en     = 1'b0;
        load_addr   = 8'h0;
        load_data   = 32'h0;

        test_reset();
        loadWord(8'd0,  32'hA0000000);
        loadWord(8'd1,  32'h8B020020);
        loadWord(8'd2,  32'hA2222222);
        loadWord(8'd3,  32'hA3333333);
        loadWord(8'd4,  32'hA4444444);
        loadWord(8'd16, 32'hF1000010);
        test_single_fetch();
        test_streaming();
        test_backpressure();
        test_flush();
        test_faults();
        test_load_collision();
        test_reset_midflight();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
